// File: rtl/pipe_adder_if.sv
// ---------------------------------------------------------------------------
// pipe_adder_if -- operand/result bus of the pipelined adder.
//
// Groups the input handshake (in_valid/in_ready), the operand set
// (a, b, carry_in, sub), the output handshake (out_valid/out_ready) and the
// result fields (sum, carry_out, overflow, zero).
//
// Modports:
//   master -- producer/consumer side: drives operands, in_valid, out_ready.
//   slave  -- the adder: drives in_ready, out_valid and the result fields.
// ---------------------------------------------------------------------------
interface pipe_adder_if #(
   parameter int WIDTH = 8
);
   // input side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             sub;

   // output side
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow, zero
   );
endinterface

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder -- carry-pipelined adder/subtractor with valid/ready flow control.
//
// The WIDTH-bit addition is split into STAGES = WIDTH/CHUNK chunks. Stage k
// adds operand chunk k plus the carry registered by stage k-1, so the carry
// chain per cycle is only CHUNK bits long. Operand chunks not yet consumed
// travel forward with the carry (skew), and the already-computed low sum
// chunks travel forward with it too (deskew), so the full result is aligned
// in the last stage, which doubles as the output register. Latency is STAGES
// cycles; throughput is one operand set per cycle.
//
// Ports:
//   clk  -- clock, rising edge
//   rst  -- synchronous, active-high reset; clears valid bits and outputs
//   bus  -- pipe_adder_if.slave:
//           in_valid/in_ready   operand handshake, in_ready = !out_valid || out_ready
//           a, b                operands
//           carry_in            LSB carry (add mode only)
//           sub                 0: a+b+carry_in, 1: a-b
//           out_valid/out_ready result handshake
//           sum                 result modulo 2^WIDTH
//           carry_out           MSB carry (sub mode: 1 = no borrow)
//           overflow            signed overflow
//           zero                sum == 0
// ---------------------------------------------------------------------------
module pipe_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input logic         clk,
   input logic         rst,
   pipe_adder_if.slave bus
);

   localparam int STAGES = WIDTH / CHUNK;

   if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_chunk_check
      $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
   end

   // ------------------------------------------------------------------------
   // Stage registers. Index k is the register written by stage k; the last
   // index is the output register. Operands are kept at full width and the
   // chunks a stage no longer needs are simply never read again.
   // ------------------------------------------------------------------------
   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] cy_q,  cy_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];   // b already inverted in sub mode
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];   // low chunks filled in so far
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   // single shared advance enable: the whole pipe moves or the whole pipe holds
   logic              adv;

   // per-stage working values, reused on every loop iteration
   int                prv;
   logic              stage_in_vld;
   logic [WIDTH-1:0]  op_a;
   logic [WIDTH-1:0]  op_b;
   logic              op_cin;
   logic [WIDTH-1:0]  part_sum;
   logic [CHUNK:0]    chunk_res;
   logic              msb_cin;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can
      // leave one unassigned; that is what keeps this block free of latches.
      adv          = !vld_q[STAGES-1] || bus.out_ready;
      vld_d        = vld_q;
      cy_d         = cy_q;
      a_d          = a_q;
      b_d          = b_q;
      sum_d        = sum_q;
      ovf_d        = ovf_q;
      zero_d       = zero_q;
      prv          = 0;
      stage_in_vld = 1'b0;
      op_a         = '0;
      op_b         = '0;
      op_cin       = 1'b0;
      part_sum     = '0;
      chunk_res    = '0;
      msb_cin      = 1'b0;

      if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            // NOTE: the working values are blocking assignments on purpose:
            // each iteration reads what it has just computed, never last
            // cycle's value.
            prv = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
               // stage 0 captures the operand set; subtraction is a + ~b + 1
               stage_in_vld = bus.in_valid;
               op_a         = bus.a;
               op_b         = bus.sub ? ~bus.b : bus.b;
               op_cin       = bus.sub | bus.carry_in;
               part_sum     = '0;
            end else begin
               stage_in_vld = vld_q[prv];
               op_a         = a_q[prv];
               op_b         = b_q[prv];
               op_cin       = cy_q[prv];
               part_sum     = sum_q[prv];
            end

            chunk_res = {1'b0, op_a[k*CHUNK +: CHUNK]}
                      + {1'b0, op_b[k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, op_cin};
            part_sum[k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];

            // valid always shifts (bubbles included); data only moves with a
            // real operand set so idle stages, and the outputs, stay quiet
            vld_d[k] = stage_in_vld;
            if (stage_in_vld) begin
               a_d[k]   = op_a;
               b_d[k]   = op_b;
               sum_d[k] = part_sum;
               cy_d[k]  = chunk_res[CHUNK];
            end
         end

         // After the loop the working values describe the last stage: the
         // carry into the MSB is recovered from the MSB sum bit and operands.
         msb_cin = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ part_sum[WIDTH-1];
         if (stage_in_vld) begin
            ovf_d  = msb_cin ^ chunk_res[CHUNK];
            zero_d = (part_sum == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: only control state and the visible result fields are reset;
         // intermediate operand/partial-sum registers are qualified by their
         // valid bits, so their contents after reset never matter.
         vld_q               <= '0;
         cy_q[STAGES-1]      <= 1'b0;
         sum_q[STAGES-1]     <= '0;
         ovf_q               <= 1'b0;
         zero_q              <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         cy_q   <= cy_d;
         a_q    <= a_d;
         b_q    <= b_d;
         sum_q  <= sum_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.sum       = sum_q[STAGES-1];
   assign bus.carry_out = cy_q[STAGES-1];
   assign bus.overflow  = ovf_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder -- self-checking bench for pipe_adder.
//
// Four instances (8/2, 8/8, 16/4, 32/1) share one stimulus stream. A monitor
// per instance predicts each accepted operand set with plain integer
// arithmetic, queues the prediction, and compares it when the result is
// consumed. Directed sections cover latency, subtraction corner cases,
// backpressure and mid-flight reset; a long random section follows.
// ---------------------------------------------------------------------------
module tb_pipe_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        carry_in;
   logic        sub;
   logic [31:0] a_drv;
   logic [31:0] b_drv;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [34:0] exp_q [4][$];   // {zero, overflow, carry_out, sum}
   int          acc_cnt [4];
   int          res_cnt [4];

   pipe_adder_if #(.WIDTH(8))  if0 ();
   pipe_adder_if #(.WIDTH(8))  if1 ();
   pipe_adder_if #(.WIDTH(16)) if2 ();
   pipe_adder_if #(.WIDTH(32)) if3 ();

   pipe_adder #(.WIDTH(8),  .CHUNK(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   pipe_adder #(.WIDTH(8),  .CHUNK(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   pipe_adder #(.WIDTH(16), .CHUNK(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   pipe_adder #(.WIDTH(32), .CHUNK(1)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;
   assign if0.carry_in = carry_in;  assign if0.sub = sub;
   assign if0.a = a_drv[7:0];       assign if0.b = b_drv[7:0];
   assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
   assign if1.carry_in = carry_in;  assign if1.sub = sub;
   assign if1.a = a_drv[7:0];       assign if1.b = b_drv[7:0];
   assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;
   assign if2.carry_in = carry_in;  assign if2.sub = sub;
   assign if2.a = a_drv[15:0];      assign if2.b = b_drv[15:0];
   assign if3.in_valid = in_valid;  assign if3.out_ready = out_ready;
   assign if3.carry_in = carry_in;  assign if3.sub = sub;
   assign if3.a = a_drv;            assign if3.b = b_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: integer arithmetic on the w-bit operand values.
   function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci,
                                          input logic sb);
      longint unsigned mask, av, bv, full, s;
      logic co, of, sa, sbit, ss;
      mask = (64'd1 << w) - 64'd1;
      av   = {32'd0, a} & mask;
      bv   = {32'd0, b} & mask;
      if (sb) begin
         full = av - bv;
         co   = (av >= bv);
      end else begin
         full = av + bv + {63'd0, ci};
         co   = full[w];
      end
      s    = full & mask;
      sa   = av[w-1];
      sbit = bv[w-1];
      ss   = s[w-1];
      of   = sb ? ((sa != sbit) && (ss != sa)) : ((sa == sbit) && (ss != sa));
      return {(s == 64'd0), of, co, s[31:0]};
   endfunction

   task automatic mon(input int idx, input int w, input logic ir, input logic ov,
                      input logic [31:0] s, input logic co, input logic of, input logic z);
      logic [34:0] e;
      if (rst) begin
         exp_q[idx].delete();
         acc_cnt[idx] = 0;
         res_cnt[idx] = 0;
      end else begin
         check($sformatf("in_ready%0d", idx), ir, !ov || out_ready);
         if (ov && out_ready) begin
            res_cnt[idx]++;
            check($sformatf("expected_pending%0d", idx), exp_q[idx].size() != 0, 1);
            if (exp_q[idx].size() != 0) begin
               e = exp_q[idx].pop_front();
               check($sformatf("result%0d", idx), {z, of, co, s}, e);
            end
         end
         if (in_valid && ir) begin
            acc_cnt[idx]++;
            exp_q[idx].push_back(model(w, a_drv, b_drv, carry_in, sub));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, 8,  if0.in_ready, if0.out_valid, 32'(if0.sum), if0.carry_out, if0.overflow, if0.zero);
      mon(1, 8,  if1.in_ready, if1.out_valid, 32'(if1.sum), if1.carry_out, if1.overflow, if1.zero);
      mon(2, 16, if2.in_ready, if2.out_valid, 32'(if2.sum), if2.carry_out, if2.overflow, if2.zero);
      mon(3, 32, if3.in_ready, if3.out_valid, if3.sum,      if3.carry_out, if3.overflow, if3.zero);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one set into idle pipes, then check instance 0's result.
   task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input logic [7:0] e_sum,
                          input logic e_co, input logic e_of, input logic e_z);
      int n;
      out_ready = 1'b1;
      a_drv = {24'd0, a};  b_drv = {24'd0, b};
      carry_in = ci;  sub = sb;  in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!if0.out_valid && n < 10) begin
         step();
         n++;
      end
      check({tag, "_seen"}, if0.out_valid, 1);
      check({tag, "_sum"}, if0.sum, e_sum);
      check({tag, "_flags"}, {if0.carry_out, if0.overflow, if0.zero}, {e_co, e_of, e_z});
      repeat (40) step();
   endtask

   initial begin
      int          lat [4];
      logic [10:0] cap;
      int          sent;
      int          base;
      logic [31:0] set_a [6];
      logic [31:0] set_b [6];

      rst = 1'b1;  in_valid = 1'b0;  out_ready = 1'b0;
      carry_in = 1'b0;  sub = 1'b0;  a_drv = '0;  b_drv = '0;
      repeat (2) step();
      rst = 1'b0;

      // ---- reset state -----------------------------------------------------
      check("rst_out_valid", if0.out_valid, 0);
      check("rst_in_ready", if0.in_ready, 1);
      check("rst_sum", if0.sum, 0);
      check("rst_flags", {if0.carry_out, if0.overflow, if0.zero}, 3'b000);
      check("rst_out_valid3", if3.out_valid, 0);

      // ---- latency per configuration, 0xFF + 0x01 -------------------------
      out_ready = 1'b1;
      a_drv = 32'hFF;  b_drv = 32'h01;  carry_in = 1'b0;  sub = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = '{0, 0, 0, 0};
      cap = '0;
      for (int c = 1; c <= 40; c++) begin
         if (if0.out_valid && lat[0] == 0) begin
            lat[0] = c;
            cap = {if0.carry_out, if0.overflow, if0.zero, if0.sum};
         end
         if (if1.out_valid && lat[1] == 0) lat[1] = c;
         if (if2.out_valid && lat[2] == 0) lat[2] = c;
         if (if3.out_valid && lat[3] == 0) lat[3] = c;
         step();
      end
      check("lat_8_2", lat[0], 4);
      check("lat_8_8", lat[1], 1);
      check("lat_16_4", lat[2], 4);
      check("lat_32_1", lat[3], 32);
      check("ff_plus_1", cap, {3'b101, 8'h00});

      // ---- subtraction and carry corner cases ------------------------------
      run_one("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      run_one("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      run_one("sub_eq",    8'h5A, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      run_one("sub_cin",   8'h03, 8'h01, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
      run_one("add_cin",   8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

      // ---- six back-to-back sets with a 3-cycle stall mid-stream ----------
      for (int i = 0; i < 6; i++) begin
         set_a[i] = $urandom;
         set_b[i] = $urandom;
      end
      sent = 0;
      base = res_cnt[0];
      carry_in = 1'b0;  sub = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         out_ready = !(cyc >= 5 && cyc < 8);
         in_valid  = (sent < 6);
         a_drv     = set_a[sent % 6];
         b_drv     = set_b[sent % 6];
         @(negedge clk);
         if (cyc >= 5 && cyc < 8) check("stall_in_ready", if0.in_ready, !if0.out_valid);
         if (in_valid && if0.in_ready) sent++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stall_sent", sent, 6);
      check("stall_results", res_cnt[0] - base, 6);

      // ---- reset with three sets in flight ---------------------------------
      for (int i = 0; i < 3; i++) begin
         a_drv = $urandom;  b_drv = $urandom;  in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b0;
      check("rst2_out_valid", if0.out_valid, 0);
      check("rst2_in_ready", if0.in_ready, 1);
      out_ready = 1'b1;
      base = res_cnt[0];
      repeat (10) step();
      check("rst2_no_ghosts", res_cnt[0] - base, 0);

      a_drv = 32'h12;  b_drv = 32'h34;  in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat[0] = 0;
      for (int c = 1; c <= 10; c++) begin
         if (if0.out_valid && lat[0] == 0) lat[0] = c;
         step();
      end
      check("rst2_latency", lat[0], 4);
      repeat (40) step();

      // ---- random traffic ---------------------------------------------------
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 10) < 7;
         a_drv     = $urandom;
         b_drv     = $urandom;
         carry_in  = 1'($urandom % 2);
         sub       = 1'($urandom % 2);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (60) step();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain_empty%0d", i), exp_q[i].size(), 0);
         check($sformatf("accept_vs_result%0d", i), res_cnt[i], acc_cnt[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL provide the parameter WIDTH, default 8, setting the operand and sum width in bits.
REQ-002 The block SHALL provide the parameter CHUNK, default 2, setting the bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, and STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a, b  input  WIDTH  unsigned or two's-complement operands.
REQ-008 carry_in  input  1  carry into the LSB; used in add mode only.
REQ-009 sub  input  1  mode: 0 = a+b+carry_in, 1 = a-b (a + ~b + 1).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carry_out  output  1  carry from the MSB; in sub mode, 1 means no borrow.
REQ-014 overflow  output  1  signed overflow of the result.
REQ-015 zero  output  1  sum equals 0.

Function
REQ-016 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; output consumption SHALL occur where out_valid and out_ready are both 1.
REQ-017 Internal enable: adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally, and SHALL be independent of in_valid.
REQ-018 When adv=1, every stage register SHALL shift forward one stage, including its valid bit; when adv=0, every stage register SHALL hold.
REQ-019 Stage k (k=0..STAGES-1) SHALL add operand bits [k*CHUNK +: CHUNK] to the carry registered by stage k-1; stage 0 uses carry_in (add) or 1 (sub).
REQ-020 Higher operand chunks SHALL be carried forward in skew registers until their stage, and lower sum chunks SHALL be carried in deskew registers, so that the full sum is aligned at the output.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid=1, with no stalls.
REQ-022 Throughput SHALL be one operand set per cycle under no backpressure; no bubble SHALL be inserted between back-to-back transfers.
REQ-023 Results SHALL emerge in acceptance order, and none SHALL be dropped or duplicated under any out_ready pattern.
REQ-024 overflow SHALL be 1 when the carry into the MSB differs from carry_out.
REQ-025 zero SHALL be 1 when all sum bits are 0; carry_out SHALL NOT affect zero.
REQ-026 In sub mode, b SHALL be inverted at stage 0 capture and carry_in SHALL be ignored.
REQ-027 When in_valid=0 and adv=1, a bubble (valid=0) SHALL enter stage 0.
REQ-028 sum, carry_out, overflow and zero SHALL be registered outputs; their value is don't-care while out_valid=0 except directly after reset.
REQ-029 With CHUNK=WIDTH, the block SHALL degenerate to a single registered stage with latency 1.

Reset
REQ-030 While rst=1 at a rising edge, all stage valid bits SHALL clear to 0, and sum, carry_out, overflow and zero SHALL clear to 0.
REQ-031 After that edge, out_valid SHALL be 0, and in_ready SHALL be 1, irrespective of out_ready.
REQ-032 rst SHALL take priority over any simultaneous transfer; in-flight operand sets SHALL be discarded, not emitted.

Verification
REQ-033 WIDTH=8, CHUNK=2: a=0xFF, b=0x01, carry_in=0, sub=0 accepted at cycle T -> out_valid=1 at T+4, sum=0x00, carry_out=1, zero=1, overflow=0.
REQ-034 sub=1, a=0x80, b=0x01 -> sum=0x7F, carry_out=1, overflow=1, zero=0; sub=1, a=0x05, b=0x07 -> sum=0xFE, carry_out=0, overflow=0.
REQ-035 Six back-to-back sets with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 exactly while out_valid=1 and out_ready=0, and all six results appear in order with none lost or duplicated.
REQ-036 rst=1 for one cycle while 3 sets are in flight -> out_valid=0 next cycle, the in-flight sets never appear, and the next accepted set appears 4 cycles after its acceptance.
REQ-037 Random a, b, carry_in, sub, in_valid and out_ready over 10k cycles, WIDTH/CHUNK in {8/2, 8/8, 16/4, 32/1} -> every output matches a reference model and the result count equals the accept count.
